// File: rtl/pcie_lane_pkg.sv
// Shared definitions for the PCIe lane datapath.
// Provides the byte width, FIFO sizing defaults, level-flag threshold
// defaults and a ceil-log2 helper used to derive address widths.
package pcie_lane_pkg;

  localparam int DATA_W             = 8;
  localparam int FIFO_DEPTH_DEFAULT = 8;
  localparam int AFULL_TH_DEFAULT   = 6;
  localparam int AEMPTY_TH_DEFAULT  = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram_8bits.sv
// DEPTH x 8 register file backing one FIFO lane.
// Ports:
//   clk            rising-edge clock
//   reset_L        async active-low reset (read register only; array is not reset)
//   we/waddr/wdata write port
//   re/raddr       read request; rdata is registered and holds when re is low
//   rdata          registered read data
module fifo_ram_8bits
  import pcie_lane_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read of an address written on the same edge returns the old contents,
  // which is what the full push+pop case relies on.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_lane_8bits.sv
// Per-lane 8-bit synchronous FIFO feeding the 2:1 lane mux.
// Ports:
//   clk, reset_L      clock, async active-low reset
//   push, data_in     write request and byte
//   pop               read request for the head byte
//   data_out          registered head byte (holds when no pop is accepted)
//   valid_out         one-cycle pulse: data_out was popped on the last edge
//   full/empty        count == DEPTH / count == 0
//   almost_full       count >= AFULL_TH
//   almost_empty      count <= AEMPTY_TH
//   count             entries stored
//   fifo_error        sticky overflow/underflow flag, cleared only by reset
module fifo_lane_8bits
  import pcie_lane_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH_DEFAULT,
  parameter int AW        = clog2(DEPTH),
  parameter int AFULL_TH  = AFULL_TH_DEFAULT,
  parameter int AEMPTY_TH = AEMPTY_TH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              fifo_error
);

  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C   = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_C  = (AW+1)'(AEMPTY_TH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic          err_now;

  always_comb begin
    full         = (count == DEPTH_C);
    empty        = (count == '0);
    almost_full  = (count >= AFULL_C);
    almost_empty = (count <= AEMPTY_C);
  end

  // A pop on empty is rejected outright, so a concurrent push never reads
  // through. A push on full is still accepted when a pop frees the head.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    err_now = (pop && empty) || (push && full && !pop);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
    end else begin
      valid_out <= do_pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (err_now) begin
        fifo_error <= 1'b1;
      end
    end
  end

  fifo_ram_8bits #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset_L (reset_L),
    .we      (do_push),
    .waddr   (wr_ptr),
    .wdata   (data_in),
    .re      (do_pop),
    .raddr   (rd_ptr),
    .rdata   (data_out)
  );

endmodule
